// File: rtl/cpu_controller.sv
// Moore sequencer for the Lab 6 CPU datapath: runs one instruction per start pulse,
// drives per-cycle register-file and datapath strobes, and counts retired instructions.
module cpu_controller #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s,
  input  logic [2:0]       opcode,
  input  logic [1:0]       op,
  output logic             w,
  output logic [2:0]       nsel,
  output logic [1:0]       vsel,
  output logic             loada,
  output logic             loadb,
  output logic             loadc,
  output logic             loads,
  output logic             asel,
  output logic             bsel,
  output logic             write,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_count
);

  localparam logic [3:0] ST_WAIT      = 4'd0;
  localparam logic [3:0] ST_DECODE    = 4'd1;
  localparam logic [3:0] ST_WRITE_IMM = 4'd2;
  localparam logic [3:0] ST_GET_A     = 4'd3;
  localparam logic [3:0] ST_GET_B     = 4'd4;
  localparam logic [3:0] ST_ALU       = 4'd5;
  localparam logic [3:0] ST_CMP_ST    = 4'd6;
  localparam logic [3:0] ST_WRITE_REG = 4'd7;
  localparam logic [3:0] ST_ILLEGAL   = 4'd8;

  logic [3:0]       state_q, state_d;
  logic [2:0]       opcode_q, opcode_d;
  logic [1:0]       op_q, op_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_WAIT;
      opcode_q <= 3'b000;
      op_q     <= 2'b00;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      op_q     <= op_d;
      count_q  <= count_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    op_d     = op_q;
    count_d  = count_q;
    case (state_q)
      ST_WAIT: begin
        if (s) begin
          opcode_d = opcode;
          op_d     = op;
          state_d  = ST_DECODE;
        end
      end
      ST_DECODE: begin
        case ({opcode_q, op_q})
          5'b110_10: state_d = ST_WRITE_IMM;
          5'b110_00: state_d = ST_GET_B;
          5'b101_00,
          5'b101_10,
          5'b101_01: state_d = ST_GET_A;
          5'b101_11: state_d = ST_GET_B;
          default:   state_d = ST_ILLEGAL;
        endcase
      end
      ST_WRITE_IMM: begin
        state_d = ST_WAIT;
        count_d = count_q + CNT_W'(1);
      end
      ST_GET_A: state_d = ST_GET_B;
      ST_GET_B: begin
        // CMP only updates status, so it skips the C register and write-back
        if (opcode_q == 3'b101 && op_q == 2'b01) state_d = ST_CMP_ST;
        else                                     state_d = ST_ALU;
      end
      ST_ALU: state_d = ST_WRITE_REG;
      ST_CMP_ST: begin
        state_d = ST_WAIT;
        count_d = count_q + CNT_W'(1);
      end
      ST_WRITE_REG: begin
        state_d = ST_WAIT;
        count_d = count_q + CNT_W'(1);
      end
      default: state_d = ST_WAIT;
    endcase
  end

  always_comb begin
    w       = 1'b0;
    nsel    = 3'b000;
    vsel    = 2'b00;
    loada   = 1'b0;
    loadb   = 1'b0;
    loadc   = 1'b0;
    loads   = 1'b0;
    asel    = 1'b0;
    bsel    = 1'b0;
    write   = 1'b0;
    illegal = 1'b0;
    case (state_q)
      ST_WAIT: w = 1'b1;
      ST_WRITE_IMM: begin
        nsel  = 3'b100;
        vsel  = 2'b10;
        write = 1'b1;
      end
      ST_GET_A: begin
        nsel  = 3'b100;
        loada = 1'b1;
      end
      ST_GET_B: begin
        nsel  = 3'b001;
        loadb = 1'b1;
      end
      ST_ALU: begin
        loadc = 1'b1;
        // MOV register form passes B through by adding it to zero
        asel  = (opcode_q == 3'b110);
      end
      ST_CMP_ST: loads = 1'b1;
      ST_WRITE_REG: begin
        nsel  = 3'b010;
        write = 1'b1;
      end
      ST_ILLEGAL: illegal = 1'b1;
      default: ;
    endcase
  end

  assign instr_count = count_q;

endmodule
